// File: rtl/wb_stream_splitter.sv
// Routes one parameter AXI-Stream into NUM_SEG consecutive segments, one output stream each.
// Segment byte lengths and the PS/PL source come from a short config stream captured before every job.
module wb_stream_splitter #(
    parameter int DATA_W  = 128,
    parameter int NUM_SEG = 2,
    parameter int LEN_W   = 31
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axis_cfg_tvalid,
    output logic                      s_axis_cfg_tready,
    input  logic [31:0]               s_axis_cfg_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    output logic [NUM_SEG-1:0]        m_axis_tvalid,
    input  logic [NUM_SEG-1:0]        m_axis_tready,
    output logic [NUM_SEG*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_SEG-1:0]        m_axis_tlast,
    output logic                      job_done,
    output logic [7:0]                status
);

    localparam int BPB   = DATA_W / 8;
    localparam int SHIFT = $clog2(BPB);

    localparam logic [1:0] ST_CFG  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Valid/ready: a beat or config word transfers on a rising clk edge where both valid and
    // ready are high; valid outputs never depend on the matching ready input.

    logic [1:0]       state_q, state_d;
    logic [3:0]       cfg_cnt_q, cfg_cnt_d;
    logic [2:0]       seg_idx_q, seg_idx_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_b_q [NUM_SEG];
    logic [LEN_W-1:0] len_b_d [NUM_SEG];
    logic             src_pl_q, src_pl_d;

    logic [LEN_W-1:0] cur_len;
    logic             cur_ready;
    logic             is_last;
    logic             run;
    logic             beat_hs;
    logic             nxt_found;
    logic [2:0]       nxt_idx;

    function automatic logic [LEN_W-1:0] bytes_to_beats(input logic [LEN_W-1:0] bytes);
        logic [LEN_W:0] sum;
        sum = {1'b0, bytes} + (LEN_W+1)'(BPB - 1);
        return LEN_W'(sum >> SHIFT);
    endfunction

    always_comb begin
        cur_len   = '0;
        cur_ready = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (3'(i) == seg_idx_q) begin
                cur_len   = len_b_q[i];
                cur_ready = m_axis_tready[i];
            end
        end
        run     = (state_q == ST_RUN);
        is_last = (beat_cnt_q == cur_len - LEN_W'(1));
        beat_hs = run && s_axis_tvalid && cur_ready;
    end

    always_comb begin
        state_d    = state_q;
        cfg_cnt_d  = cfg_cnt_q;
        seg_idx_d  = seg_idx_q;
        beat_cnt_d = beat_cnt_q;
        src_pl_d   = src_pl_q;
        nxt_found  = 1'b0;
        nxt_idx    = '0;
        for (int i = 0; i < NUM_SEG; i++) len_b_d[i] = len_b_q[i];

        case (state_q)
            ST_CFG: begin
                if (s_axis_cfg_tvalid) begin
                    for (int i = 0; i < NUM_SEG; i++) begin
                        if (4'(i) == cfg_cnt_q) len_b_d[i] = bytes_to_beats(s_axis_cfg_tdata[LEN_W-1:0]);
                    end
                    if (cfg_cnt_q == 4'd0) src_pl_d = s_axis_cfg_tdata[31];
                    cfg_cnt_d = cfg_cnt_q + 4'd1;
                    if (cfg_cnt_q == 4'(NUM_SEG - 1)) begin
                        // Descending scan leaves the lowest nonzero segment selected.
                        for (int i = NUM_SEG - 1; i >= 0; i--) begin
                            if (len_b_d[i] != '0) begin
                                nxt_found = 1'b1;
                                nxt_idx   = 3'(i);
                            end
                        end
                        if (src_pl_d || !nxt_found) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_RUN;
                            seg_idx_d  = nxt_idx;
                            beat_cnt_d = '0;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (beat_hs) begin
                    if (is_last) begin
                        beat_cnt_d = '0;
                        for (int i = NUM_SEG - 1; i >= 0; i--) begin
                            if (3'(i) > seg_idx_q && len_b_q[i] != '0) begin
                                nxt_found = 1'b1;
                                nxt_idx   = 3'(i);
                            end
                        end
                        if (nxt_found) seg_idx_d = nxt_idx;
                        else           state_d   = ST_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                cfg_cnt_d = '0;
                state_d   = ST_CFG;
            end
            default: state_d = ST_CFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CFG;
            cfg_cnt_q  <= '0;
            seg_idx_q  <= '0;
            beat_cnt_q <= '0;
            src_pl_q   <= 1'b0;
            for (int i = 0; i < NUM_SEG; i++) len_b_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cfg_cnt_q  <= cfg_cnt_d;
            seg_idx_q  <= seg_idx_d;
            beat_cnt_q <= beat_cnt_d;
            src_pl_q   <= src_pl_d;
            for (int i = 0; i < NUM_SEG; i++) len_b_q[i] <= len_b_d[i];
        end
    end

    // Gating with rst_n keeps upstream from seeing a config word accepted while reset is held.
    always_comb begin
        s_axis_cfg_tready = rst_n && (state_q == ST_CFG);
        s_axis_tready     = run && cur_ready;
        job_done          = (state_q == ST_DONE);
        status            = {3'b000, seg_idx_q, state_q};
        m_axis_tvalid     = '0;
        m_axis_tlast      = '0;
        m_axis_tdata      = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (run && 3'(i) == seg_idx_q) begin
                m_axis_tvalid[i]                = s_axis_tvalid;
                m_axis_tlast[i]                 = is_last;
                m_axis_tdata[i*DATA_W +: DATA_W] = s_axis_tdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_stream_splitter.sv
// Directed bench for wb_stream_splitter with three segments of 128-bit data.
// Outputs are sampled 1 ns after the falling edge; inputs change 1 ns after the rising edge or at the falling edge.
module tb_wb_stream_splitter;

    localparam int DATA_W  = 128;
    localparam int NUM_SEG = 3;
    localparam int LEN_W   = 31;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cfg_valid;
    logic                      cfg_tready;
    logic [31:0]               cfg_data;
    logic                      s_valid;
    logic                      s_tready;
    logic [DATA_W-1:0]         s_data;
    logic [NUM_SEG-1:0]        m_tvalid;
    logic [NUM_SEG-1:0]        m_ready;
    logic [NUM_SEG*DATA_W-1:0] m_tdata;
    logic [NUM_SEG-1:0]        m_tlast;
    logic                      job_done;
    logic [7:0]                status;

    int total = 0;
    int bad   = 0;

    wb_stream_splitter #(.DATA_W(DATA_W), .NUM_SEG(NUM_SEG), .LEN_W(LEN_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_cfg_tvalid (cfg_valid),
        .s_axis_cfg_tready (cfg_tready),
        .s_axis_cfg_tdata  (cfg_data),
        .s_axis_tvalid     (s_valid),
        .s_axis_tready     (s_tready),
        .s_axis_tdata      (s_data),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_ready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tlast      (m_tlast),
        .job_done          (job_done),
        .status            (status)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_word(input logic [31:0] w);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = w;
        #1;
        n = 0;
        while (!cfg_tready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("cfg_accept", 384'(cfg_tready), 384'(1));
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    // Drives beats first..stop-1 of an n_beats segment with ready asserted everywhere.
    task automatic run_seg(input int seg, input int first, input int stop, input int n_beats,
                           input logic [31:0] base);
        logic [2:0]   ev;
        logic [383:0] exp_all;
        logic [127:0] beat;
        for (int b = first; b < stop; b++) begin
            ev      = 3'(1 << seg);
            beat    = {96'h0, base + 32'(b)};
            exp_all = '0;
            exp_all[seg*128 +: 128] = beat;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = beat;
            m_ready = '1;
            #1;
            check("seg_valid", 384'(m_tvalid), 384'(ev));
            check("seg_data", m_tdata, exp_all);
            check("seg_last", 384'(m_tlast), (b == n_beats - 1) ? 384'(ev) : 384'(0));
            check("in_ready", 384'(s_tready), 384'(1));
            check("cfg_stall", 384'(cfg_tready), 384'(0));
            check("run_status", 384'(status), 384'({3'b000, 3'(seg), 2'b01}));
            @(posedge clk);
            #1 s_valid = 1'b0;
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        s_valid = 1'b1;
        #1;
        check("done_pulse", 384'(job_done), 384'(1));
        check("done_state", 384'(status[1:0]), 384'(2));
        check("done_in_stall", 384'(s_tready), 384'(0));
        check("done_no_valid", 384'(m_tvalid), 384'(0));
        check("done_cfg_stall", 384'(cfg_tready), 384'(0));
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check("done_once", 384'(job_done), 384'(0));
        check("back_to_cfg", 384'(status[1:0]), 384'(0));
        check("cfg_ready", 384'(cfg_tready), 384'(1));
    endtask

    function automatic int rnd_seg(input int k);
        return (k < 3) ? 0 : ((k < 5) ? 1 : 2);
    endfunction

    initial begin
        logic [31:0]  exp_q[$];
        logic [383:0] exp_all;
        logic [2:0]   ev;
        logic         hs;
        int           k;
        int           cyc;
        int           sg;

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = '1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cfg_ready", 384'(cfg_tready), 384'(0));
        check("rst_valid", 384'(m_tvalid), 384'(0));
        check("rst_status", 384'(status), 384'(0));
        check("rst_done", 384'(job_done), 384'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_cfg_ready", 384'(cfg_tready), 384'(1));
        check("idle_in_ready", 384'(s_tready), 384'(0));

        // Two-segment split: 0x40 bytes -> 4 beats, 0x80 -> 8 beats, third segment empty
        cfg_word(32'h0000_0040);
        cfg_word(32'h0000_0080);
        cfg_word(32'h0000_0000);
        run_seg(0, 0, 4, 4, 32'h1000_0000);
        run_seg(1, 0, 8, 8, 32'h2000_0000);
        check_done();

        // PL source: the job is skipped entirely
        cfg_word(32'h8000_0040);
        cfg_word(32'h0000_0080);
        cfg_word(32'h0000_0010);
        check_done();

        // Zero-length middle segment, 33 bytes -> 3 beats
        cfg_word(32'h0000_0010);
        cfg_word(32'h0000_0000);
        cfg_word(32'h0000_0021);
        run_seg(0, 0, 1, 1, 32'h3000_0000);
        run_seg(2, 0, 3, 3, 32'h3100_0000);
        check_done();

        // Random source valid and downstream ready: 3 + 2 + 4 beats
        cfg_word(32'h0000_0030);
        cfg_word(32'h0000_0020);
        cfg_word(32'h0000_0040);
        for (int i = 0; i < 9; i++) exp_q.push_back(32'hC0DE_0000 + 32'(i));
        k   = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            sg      = rnd_seg(k);
            ev      = 3'(1 << sg);
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 3'($urandom_range(0, 7));
            s_data  = {96'h0, exp_q[0]};
            exp_all = '0;
            if (s_valid) exp_all[sg*128 +: 128] = {96'h0, exp_q[0]};
            #1;
            check("rnd_valid", 384'(m_tvalid), s_valid ? 384'(ev) : 384'(0));
            check("rnd_ready", 384'(s_tready), 384'(m_ready[sg]));
            if (s_valid) begin
                check("rnd_data", m_tdata, exp_all);
                check("rnd_last", 384'(m_tlast), (k == 2 || k == 4 || k == 8) ? 384'(ev) : 384'(0));
            end
            hs = s_valid && m_ready[sg];
            @(posedge clk);
            if (hs) begin
                void'(exp_q.pop_front());
                k++;
            end
            cyc++;
            #1 s_valid = 1'b0;
        end
        check("rnd_all_beats", 384'(k), 384'(9));
        m_ready = '1;
        check_done();

        // Reset during beat 3 of segment 1
        cfg_word(32'h0000_0020);
        cfg_word(32'h0000_0040);
        cfg_word(32'h0000_0000);
        run_seg(0, 0, 2, 2, 32'h5000_0000);
        run_seg(1, 0, 2, 4, 32'h5100_0000);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 128'h5100_0002;
        rst_n   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", 384'(m_tvalid), 384'(0));
        check("mid_rst_data", m_tdata, 384'(0));
        check("mid_rst_last", 384'(m_tlast), 384'(0));
        check("mid_rst_in_ready", 384'(s_tready), 384'(0));
        check("mid_rst_done", 384'(job_done), 384'(0));
        check("mid_rst_status", 384'(status), 384'(0));
        check("mid_rst_cfg_ready", 384'(cfg_tready), 384'(1));
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_no_done", 384'(job_done), 384'(0));
        cfg_word(32'h0000_0010);
        cfg_word(32'h0000_0010);
        cfg_word(32'h0000_0010);
        run_seg(0, 0, 1, 1, 32'h6000_0000);
        run_seg(1, 0, 1, 1, 32'h6100_0000);
        run_seg(2, 0, 1, 1, 32'h6200_0000);
        check_done();

        // Config word presented during RUN waits until the job has finished
        cfg_word(32'h0000_0020);
        cfg_word(32'h0000_0000);
        cfg_word(32'h0000_0000);
        cfg_valid = 1'b1;
        cfg_data  = 32'h0000_0030;
        run_seg(0, 0, 2, 2, 32'h7000_0000);
        check_done();
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        cfg_word(32'h0000_0010);
        cfg_word(32'h0000_0000);
        run_seg(0, 0, 3, 3, 32'h7100_0000);
        run_seg(1, 0, 1, 1, 32'h7200_0000);
        check_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
